// File: rtl/adc_scope_if.sv
// ---------------------------------------------------------------------------
// adc_scope_if
// Bundles the signals of the triggered capture buffer: the ADC sample stream,
// the trigger/arm controls, the renderer read port and the status flags.
//   master : ADC/renderer/control side. Drives samples, controls and rd_addr.
//            Receives rd_data, busy, done and trig_forced.
//   slave  : the capture buffer (adc_scope_capture).
// Parameter DEPTH_LOG2 sets the read-address width.
// ---------------------------------------------------------------------------
interface adc_scope_if #(
  parameter int DEPTH_LOG2 = 9
);
  logic [23:0]           adc_data;     // [11:0] ch0, [23:12] ch1, unsigned
  logic                  adc_sync;     // toggles once per new adc_data word
  logic                  arm;          // 1-cycle pulse: start/restart a capture
  logic                  trig_ch;      // 0 = ch0, 1 = ch1
  logic                  trig_edge;    // 0 = rising, 1 = falling
  logic [11:0]           trig_level;   // unsigned threshold
  logic                  auto_mode;    // enables the timeout trigger
  logic [DEPTH_LOG2-1:0] rd_addr;      // relative to window start
  logic [23:0]           rd_data;      // 1-cycle read latency
  logic                  busy;
  logic                  done;
  logic                  trig_forced;

  modport master (
    output adc_data, adc_sync, arm, trig_ch, trig_edge, trig_level,
           auto_mode, rd_addr,
    input  rd_data, busy, done, trig_forced
  );

  modport slave (
    input  adc_data, adc_sync, arm, trig_ch, trig_edge, trig_level,
           auto_mode, rd_addr,
    output rd_data, busy, done, trig_forced
  );
endinterface

// File: rtl/adc_scope_capture.sv
// ---------------------------------------------------------------------------
// adc_scope_capture
// Triggered waveform capture buffer between the stereo ADC interface and the
// video renderer. Records a window of 2**DEPTH_LOG2 stereo samples around a
// level-crossing trigger: PRETRIG samples before the trigger sample, the
// trigger sample itself, and the rest after it.
//
// Ports:
//   clk    ADC clock (shared with the ADC interface)
//   reset  asynchronous, active-high
//   bus    adc_scope_if.slave:
//            adc_data/adc_sync  sample word and its toggle-type sync
//            arm                start/restart a capture
//            trig_ch/trig_edge/trig_level  trigger selection
//            auto_mode          timeout trigger enable
//            rd_addr/rd_data    window read port, 0 = oldest pre-trigger
//            busy/done/trig_forced  status
//
// Build option: define ADC_SCOPE_AUTOTRIG_EN to include the timeout trigger.
// Without it auto_mode is ignored, trig_forced is 0 and WAIT_TRIG waits
// forever.
// ---------------------------------------------------------------------------
module adc_scope_capture #(
  parameter int DEPTH_LOG2   = 9,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  adc_scope_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  localparam addr_t PRETRIG_A    = addr_t'(PRETRIG);
  localparam addr_t PREFILL_LAST = addr_t'(PRETRIG - 1);
  // Samples written after the trigger sample to complete the window.
  localparam addr_t POST_INIT    = addr_t'(DEPTH - PRETRIG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic        sync_d;
  logic        stb;
  logic        capturing;
  logic        wr_en;
  logic [11:0] cur;
  logic [11:0] prev;
  logic        prev_valid;
  logic        rise_x;
  logic        fall_x;
  logic        real_trig;
  logic        forced_trig;
  logic        trig_hit;
  addr_t       wr_ptr;
  addr_t       start;
  addr_t       prefill_cnt;
  addr_t       post_cnt;
  addr_t       rd_ptr;
  logic [23:0] ram [DEPTH];
  logic [23:0] rd_q;

  // -------------------------------------------------------------------------
  // Sample strobe and trigger detection
  // -------------------------------------------------------------------------
  assign stb       = bus.adc_sync ^ sync_d;
  assign capturing = (state == S_PREFILL) || (state == S_WAIT_TRIG) ||
                     (state == S_POST);
  // arm takes priority: a sample coinciding with arm is dropped.
  assign wr_en     = stb && capturing && !bus.arm;

  assign cur    = bus.trig_ch ? bus.adc_data[23:12] : bus.adc_data[11:0];
  assign rise_x = (prev <  bus.trig_level) && (cur >= bus.trig_level);
  assign fall_x = (prev >= bus.trig_level) && (cur <  bus.trig_level);
  // prev_valid blocks a false crossing against stale data right after arm.
  assign real_trig = (state == S_WAIT_TRIG) && prev_valid &&
                     (bus.trig_edge ? fall_x : rise_x);
  assign trig_hit  = wr_en && (state == S_WAIT_TRIG) &&
                     (real_trig || forced_trig);

  // -------------------------------------------------------------------------
  // Optional timeout trigger
  // -------------------------------------------------------------------------
`ifdef ADC_SCOPE_AUTOTRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            trig_forced_q;

  // to_cnt holds the number of WAIT_TRIG samples already seen, so the
  // AUTO_TIMEOUT-th one is forced.
  assign forced_trig = bus.auto_mode && (state == S_WAIT_TRIG) &&
                       (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt        <= '0;
      trig_forced_q <= 1'b0;
    end else if (bus.arm) begin
      to_cnt        <= '0;
      trig_forced_q <= 1'b0;
    end else if ((state != S_WAIT_TRIG) || !bus.auto_mode) begin
      to_cnt <= '0;
    end else if (wr_en) begin
      if (trig_hit) trig_forced_q <= !real_trig;
      else          to_cnt        <= to_cnt + TO_W'(1);
    end
  end

  assign bus.trig_forced = trig_forced_q;
`else
  logic unused_auto_mode;
  assign unused_auto_mode = bus.auto_mode;
  assign forced_trig      = 1'b0;
  assign bus.trig_forced  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block order.
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch forms.
    state_nx = state;
    if (bus.arm) begin
      state_nx = (PRETRIG == 0) ? S_WAIT_TRIG : S_PREFILL;
    end else if (wr_en) begin
      case (state)
        S_PREFILL:   if (prefill_cnt == PREFILL_LAST) state_nx = S_WAIT_TRIG;
        S_WAIT_TRIG: if (trig_hit)
                       state_nx = (POST_INIT == '0) ? S_DONE : S_POST;
        S_POST:      if (post_cnt == addr_t'(1)) state_nx = S_DONE;
        default:     state_nx = state;
      endcase
    end
  end

  assign bus.busy = capturing;
  assign bus.done = (state == S_DONE);

  // -------------------------------------------------------------------------
  // Pointers, counters and trigger history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d      <= 1'b0;
      wr_ptr      <= '0;
      start       <= '0;
      prefill_cnt <= '0;
      post_cnt    <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
    end else begin
      sync_d <= bus.adc_sync;
      if (bus.arm) begin
        wr_ptr      <= '0;
        prefill_cnt <= '0;
        post_cnt    <= '0;
        prev_valid  <= 1'b0;
      end else if (wr_en) begin
        wr_ptr     <= wr_ptr + addr_t'(1);
        prev       <= cur;
        prev_valid <= 1'b1;
        case (state)
          S_PREFILL:   prefill_cnt <= prefill_cnt + addr_t'(1);
          S_WAIT_TRIG: if (trig_hit) begin
                         // Window start: PRETRIG slots behind the trigger.
                         start    <= wr_ptr - PRETRIG_A;
                         post_cnt <= POST_INIT;
                       end
          S_POST:      post_cnt <= post_cnt - addr_t'(1);
          default:     post_cnt <= post_cnt;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Simple dual-port sample memory
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset so it maps onto block RAM; its contents
  // survive reset and are only meaningful once done is set.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= bus.adc_data;
  end

  assign rd_ptr = start + bus.rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= ram[rd_ptr];
  end

  assign bus.rd_data = rd_q;

endmodule
